pmp_checker: RTL and testbench

- Sequential RISC-V PMP unit. Holds the pmpcfg/pmpaddr CSRs and answers one access-permission request at a time.
- Scans entries one per cycle, lowest index first, using the team's existing per-entry match block addr_check_n. The first matching entry decides the result.
- Sits between the load/store/fetch address path and the memory interface. Its fault output feeds trap logic.

---
 rtl/cep_define.sv | 46 ++++
 rtl/addr_check_n.sv | 42 ++++
 rtl/pmp_csr_file.sv | 95 +++++++++
 rtl/pmp_checker.sv | 163 ++++++++++++++++
 tb/tb_pmp_checker.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cep_define.sv
// Shared types and constants for the PMP checker.
// Latency: n/a (package).
// Backpressure: n/a (package).
package cep_define;

  // One pmpcfg byte: L[7], reserved[6:5], A[4:3], X[2], W[1], R[0].
  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    logic [1:0] a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;

  localparam logic [1:0] A_OFF   = 2'd0;
  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;

  localparam logic [1:0] REQ_READ  = 2'd0;
  localparam logic [1:0] REQ_WRITE = 2'd1;
  localparam logic [1:0] REQ_EXEC  = 2'd2;
  localparam logic [1:0] REQ_RSVD  = 2'd3;

  localparam logic [11:0] CSR_PMPCFG_BASE  = 12'h3A0;
  localparam logic [11:0] CSR_PMPADDR_BASE = 12'h3B0;
  localparam logic [11:0] CSR_FLOG_ADDR    = 12'h7C0;
  localparam logic [11:0] CSR_FLOG_FLAG    = 12'h7C1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } pmp_state_e;

  // Reserved bits always store 0; W without R is not a legal combination.
  function automatic pmp_cfg_t cfg_legalize(input logic [7:0] b);
    pmp_cfg_t c;
    c      = pmp_cfg_t'(b);
    c.rsvd = 2'b00;
    if (c.w && !c.r) c.w = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/addr_check_n.sv
// Per-entry PMP address match: OFF / TOR / NA4 / NAPOT against one entry.
// Latency: combinational.
// Backpressure: none.
// Ports: addr_i byte address, size_i log2 access bytes, addr_n_i / addr_n_1_i
//        pmpaddr of this and the previous entry, a_n_i A-field, match_o.
// Match means the whole access (first and last byte) lies inside the region.
module addr_check_n
  import cep_define::*;
(
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_n_i,
  input  logic [31:0] addr_n_1_i,
  input  logic [1:0]  a_n_i,
  output logic        match_o
);

  logic [33:0] first_b;
  logic [33:0] last_b;
  logic [31:0] napot_mask;

  assign first_b = {2'b00, addr_i};
  assign last_b  = first_b + ((34'd1 << size_i) - 34'd1);
  // Trailing ones of pmpaddr plus the next zero bit: the NAPOT don't-care word bits.
  assign napot_mask = addr_n_i ^ (addr_n_i + 32'd1);

  function automatic logic byte_hit(input logic [33:0] b);
    logic r;
    r = 1'b0;
    case (a_n_i)
      A_OFF:   r = 1'b0;
      A_TOR:   r = (b >= {addr_n_1_i, 2'b00}) && (b < {addr_n_i, 2'b00});
      A_NA4:   r = (b[33:2] == addr_n_i);
      A_NAPOT: r = ((b[33:2] | napot_mask) == (addr_n_i | napot_mask));
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign match_o = byte_hit(first_b) && byte_hit(last_b);

endmodule

// File: rtl/pmp_csr_file.sv
// PMP CSR storage: pmpcfg bytes, pmpaddr words, lock rules, read mux, optional fault log.
// Latency: writes visible next cycle; reads combinational.
// Backpressure: none, every CSR access completes in its cycle.
// Ports: clk_i/rst_i, csr_we_i/csr_addr_i/csr_wdata_i/csr_rdata_o, log_vld_i/log_addr_i
//        fault event from the checker, cfg_o/addr_o current entry registers.
// Macro PMP_FAULT_LOG_EN adds the fault-address register and sticky flag at 0x7C0/0x7C1.
module pmp_csr_file
  import cep_define::*;
#(
  parameter int NUM_ENTRIES = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               csr_we_i,
  input  logic [11:0]                        csr_addr_i,
  input  logic [31:0]                        csr_wdata_i,
  output logic [31:0]                        csr_rdata_o,
  input  logic                               log_vld_i,
  input  logic [31:0]                        log_addr_i,
  output pmp_cfg_t [NUM_ENTRIES-1:0]         cfg_o,
  output logic     [NUM_ENTRIES-1:0][31:0]   addr_o
);

  pmp_cfg_t [NUM_ENTRIES-1:0]       cfg_q;
  logic     [NUM_ENTRIES-1:0][31:0] addr_q;
  // tor_lock[i]: entry i is locked TOR, which also freezes pmpaddr[i-1].
  logic     [NUM_ENTRIES:0]         tor_lock;

  always_comb begin
    tor_lock = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      tor_lock[i] = cfg_q[i].l && (cfg_q[i].a == A_TOR);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_q  <= '0;
      addr_q <= '0;
    end else if (csr_we_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if ((csr_addr_i == CSR_PMPCFG_BASE + 12'(i >> 2)) && !cfg_q[i].l) begin
          cfg_q[i] <= cfg_legalize(csr_wdata_i[8*(i%4) +: 8]);
        end
        if ((csr_addr_i == CSR_PMPADDR_BASE + 12'(i)) && !cfg_q[i].l && !tor_lock[i+1]) begin
          addr_q[i] <= csr_wdata_i;
        end
      end
    end
  end

`ifdef PMP_FAULT_LOG_EN
  logic [31:0] flog_addr_q;
  logic        flog_flag_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flog_addr_q <= '0;
      flog_flag_q <= 1'b0;
    end else begin
      if (log_vld_i) begin
        flog_addr_q <= log_addr_i;
        flog_flag_q <= 1'b1;
      end else if (csr_we_i && (csr_addr_i == CSR_FLOG_FLAG)) begin
        flog_flag_q <= 1'b0;
      end
    end
  end
`else
  logic unused_log;
  assign unused_log = ^{log_vld_i, log_addr_i};
`endif

  always_comb begin
    csr_rdata_o = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (csr_addr_i == CSR_PMPCFG_BASE + 12'(i >> 2)) begin
        csr_rdata_o[8*(i%4) +: 8] = cfg_q[i];
      end
      if (csr_addr_i == CSR_PMPADDR_BASE + 12'(i)) begin
        csr_rdata_o = addr_q[i];
      end
    end
`ifdef PMP_FAULT_LOG_EN
    if (csr_addr_i == CSR_FLOG_ADDR) csr_rdata_o = flog_addr_q;
    if (csr_addr_i == CSR_FLOG_FLAG) csr_rdata_o = {31'b0, flog_flag_q};
`else
    if ((csr_addr_i == CSR_FLOG_ADDR) || (csr_addr_i == CSR_FLOG_FLAG)) csr_rdata_o = '0;
`endif
  end

  assign cfg_o  = cfg_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/pmp_checker.sv
// Sequential RISC-V PMP: scans one entry per cycle, lowest first; first match decides.
// Latency: accept at T, hit on entry k -> resp_valid at T+2+k, no hit -> T+1+NUM_ENTRIES.
// Backpressure: req_ready is low from acceptance until the response cycle has passed.
// Ports: clk/rst, req_* request (valid/ready), resp_* one-cycle result strobe with held
//        fault/hit/entry, csr_* CSR write port and combinational read.
// Macro PMP_FAULT_LOG_EN enables the fault log CSRs 0x7C0/0x7C1.
module pmp_checker
  import cep_define::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_addr,
  input  logic [1:0]       req_size,
  input  logic [1:0]       req_type,
  input  logic             req_mmode,
  output logic             resp_valid,
  output logic             resp_fault,
  output logic             resp_hit,
  output logic [IDX_W-1:0] resp_entry,
  input  logic             csr_we,
  input  logic [11:0]      csr_addr,
  input  logic [31:0]      csr_wdata,
  output logic [31:0]      csr_rdata
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  pmp_state_e       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      addr_q;
  logic [1:0]       size_q;
  logic [1:0]       type_q;
  logic             mmode_q;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic             resp_fault_q;
  logic             resp_hit_q;
  logic [IDX_W-1:0] resp_entry_q;

  pmp_cfg_t [NUM_ENTRIES-1:0]       cfg;
  logic     [NUM_ENTRIES-1:0][31:0] pmpaddr;

  pmp_cfg_t    cur_cfg;
  logic [31:0] cur_addr_n;
  logic [31:0] cur_addr_n_1;
  logic        entry_match;

  pmp_csr_file #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_csr (
    .clk_i      (clk),
    .rst_i      (rst),
    .csr_we_i   (csr_we),
    .csr_addr_i (csr_addr),
    .csr_wdata_i(csr_wdata),
    .csr_rdata_o(csr_rdata),
    .log_vld_i  (resp_valid_q & resp_fault_q),
    .log_addr_i (addr_q),
    .cfg_o      (cfg),
    .addr_o     (pmpaddr)
  );

  // Live register values each cycle, so CSR writes during a scan are seen immediately.
  assign cur_cfg      = cfg[idx_q];
  assign cur_addr_n   = pmpaddr[idx_q];
  assign cur_addr_n_1 = (idx_q == '0) ? 32'd0 : pmpaddr[idx_q - IDX_W'(1)];

  addr_check_n u_match (
    .addr_i    (addr_q),
    .size_i    (size_q),
    .addr_n_i  (cur_addr_n),
    .addr_n_1_i(cur_addr_n_1),
    .a_n_i     (cur_cfg.a),
    .match_o   (entry_match)
  );

  function automatic logic calc_fault(input logic hit, input pmp_cfg_t c,
                                      input logic [1:0] t, input logic m);
    logic f;
    if (t == REQ_RSVD) begin
      f = 1'b1;
    end else if (hit) begin
      if (m && !c.l) begin
        f = 1'b0;
      end else begin
        case (t)
          REQ_READ:  f = !c.r;
          REQ_WRITE: f = !c.w;
          REQ_EXEC:  f = !c.x;
          default:   f = 1'b1;
        endcase
      end
    end else begin
      f = !m;
    end
    return f;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      addr_q       <= '0;
      size_q       <= '0;
      type_q       <= '0;
      mmode_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_entry_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr;
            size_q      <= req_size;
            type_q      <= req_type;
            mmode_q     <= req_mmode;
            idx_q       <= '0;
            req_ready_q <= 1'b0;
            state_q     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (entry_match) begin
            resp_hit_q   <= 1'b1;
            resp_entry_q <= idx_q;
            resp_fault_q <= calc_fault(1'b1, cur_cfg, type_q, mmode_q);
            resp_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end else if (idx_q == LAST_IDX) begin
            resp_hit_q   <= 1'b0;
            resp_entry_q <= '0;
            resp_fault_q <= calc_fault(1'b0, cur_cfg, type_q, mmode_q);
            resp_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          resp_valid_q <= 1'b0;
          req_ready_q  <= 1'b1;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_fault = resp_fault_q;
  assign resp_hit   = resp_hit_q;
  assign resp_entry = resp_entry_q;

endmodule

// File: tb/tb_pmp_checker.sv
// Scoreboard bench for pmp_checker: expected responses queued at request time,
// popped and compared when resp_valid is seen; CSR reads compared directly.
module tb_pmp_checker;

  localparam int NUM = 16;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [1:0]  req_type;
  logic        req_mmode;
  logic        resp_valid;
  logic        resp_fault;
  logic        resp_hit;
  logic [3:0]  resp_entry;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;

  pmp_checker #(.NUM_ENTRIES(NUM), .IDX_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_type  (req_type),
    .req_mmode (req_mmode),
    .resp_valid(resp_valid),
    .resp_fault(resp_fault),
    .resp_hit  (resp_hit),
    .resp_entry(resp_entry),
    .csr_we    (csr_we),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .csr_rdata (csr_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       f;
    logic       h;
    logic [3:0] e;
    int         lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Cycle counter and acceptance stamp; latency = cycles from the accepting cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) acc_cyc <= cyc;
  end

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (sb.size() == 0) begin
        chk("unexp_resp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("fault", {31'b0, resp_fault}, {31'b0, mon_e.f});
        chk("hit", {31'b0, resp_hit}, {31'b0, mon_e.h});
        chk("entry", {28'b0, resp_entry}, {28'b0, mon_e.e});
        chk("latency", cyc - acc_cyc, mon_e.lat);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    @(negedge clk);
    csr_we    = 1'b0;
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    @(negedge clk);
    csr_addr = a;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [1:0] t, input logic m,
                        input logic ef, input logic eh, input logic [3:0] ee, input int el);
    exp_t e;
    int   n;
    e.f = ef; e.h = eh; e.e = ee; e.lat = el;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = 2'd2;
    req_type  = t;
    req_mmode = m;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0; req_type = '0;
    req_mmode = 1'b0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
    do_reset();

    // Reset state and empty table
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_fault", {31'b0, resp_fault}, 32'd0);
    chk("rst_hit", {31'b0, resp_hit}, 32'd0);
    chk("rst_entry", {28'b0, resp_entry}, 32'd0);
    csr_rd("rst_cfg0", 12'h3A0, 32'h0);
    csr_rd("rst_addr0", 12'h3B0, 32'h0);
    do_req(32'h0000_1000, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 17);
    do_req(32'h0000_1000, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 17);

    // NAPOT entry 0, R+W
    csr_wr(12'h3B0, 32'h2000_01FF);
    csr_wr(12'h3A0, 32'h0000_001B);
    csr_rd("napot_cfg", 12'h3A0, 32'h0000_001B);
    do_req(32'h8000_0F00, 2'd1, 1'b0, 1'b0, 1'b1, 4'd0, 2);
    do_req(32'h8000_0F00, 2'd2, 1'b0, 1'b1, 1'b1, 4'd0, 2);
    do_req(32'h8000_0F00, 2'd2, 1'b1, 1'b0, 1'b1, 4'd0, 2);
    do_req(32'h8000_0F00, 2'd3, 1'b1, 1'b1, 1'b1, 4'd0, 2);
    do_req(32'h8000_1000, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 17);

    // TOR entry 1, R only
    do_reset();
    csr_wr(12'h3B0, 32'h0000_0400);
    csr_wr(12'h3B1, 32'h0000_0800);
    csr_wr(12'h3A0, 32'h0000_0900);
    do_req(32'h0000_1800, 2'd0, 1'b0, 1'b0, 1'b1, 4'd1, 3);
    @(negedge clk);
    chk("hold_entry", {28'b0, resp_entry}, 32'd1);
    do_req(32'h0000_2000, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 17);
    do_req(32'h0000_0FFC, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 17);
    do_req(32'h0000_1000, 2'd1, 1'b0, 1'b1, 1'b1, 4'd1, 3);

    // Legalization: W without R dropped, reserved bits cleared
    csr_wr(12'h3A0, 32'h0000_7F02);
    csr_rd("warl_cfg", 12'h3A0, 32'h0000_1F00);

    // Locks
    do_reset();
    csr_wr(12'h3B2, 32'h0000_1234);
    csr_wr(12'h3A0, 32'h0080_0000);
    csr_wr(12'h3A0, 32'h001F_0000);
    csr_rd("lock_cfg", 12'h3A0, 32'h0080_0000);
    csr_wr(12'h3B2, 32'h0000_5678);
    csr_rd("lock_addr", 12'h3B2, 32'h0000_1234);
    csr_wr(12'h3B4, 32'h0000_AAAA);
    csr_wr(12'h3A1, 32'h0000_8800);
    csr_wr(12'h3B4, 32'h0000_BBBB);
    csr_rd("torlock_prev", 12'h3B4, 32'h0000_AAAA);
    csr_wr(12'h3B5, 32'h0000_CCCC);
    csr_rd("torlock_self", 12'h3B5, 32'h0000_0000);
    csr_rd("cfg1_rd", 12'h3A1, 32'h0000_8800);

    // Overlap: entry 0 (R) and entry 3 (RWX) both cover 0x100
    csr_wr(12'h3B0, 32'h0000_0040);
    csr_wr(12'h3B3, 32'h0000_0040);
    csr_wr(12'h3A0, 32'h1780_0011);
    csr_rd("ovl_cfg", 12'h3A0, 32'h1780_0011);
    do_req(32'h0000_0100, 2'd1, 1'b0, 1'b1, 1'b1, 4'd0, 2);
    do_req(32'h0000_0100, 2'd0, 1'b0, 1'b0, 1'b1, 4'd0, 2);

    // Unmapped
    csr_wr(12'h3C0, 32'hFFFF_FFFF);
    csr_rd("unmapped", 12'h3C0, 32'h0);
    csr_rd("cfg_hi", 12'h3A4, 32'h0);

    // Fault log
    do_reset();
    do_req(32'hDEAD_BEE0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0, 17);
`ifdef PMP_FAULT_LOG_EN
    csr_rd("flog_addr", 12'h7C0, 32'hDEAD_BEE0);
    csr_rd("flog_flag", 12'h7C1, 32'h1);
    csr_wr(12'h7C1, 32'h0);
    csr_rd("flog_clr", 12'h7C1, 32'h0);
    csr_rd("flog_addr_keep", 12'h7C0, 32'hDEAD_BEE0);
`else
    csr_rd("flog_addr_off", 12'h7C0, 32'h0);
    csr_rd("flog_flag_off", 12'h7C1, 32'h0);
`endif

    // Reset in the middle of a scan: no response may appear
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0000_1000; req_type = 2'd0; req_mmode = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midscan_busy", {31'b0, req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("midscan_novalid", {31'b0, resp_valid}, 32'd0);
    chk("midscan_ready", {31'b0, req_ready}, 32'd1);
    do_req(32'h0000_1000, 2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 17);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
